// File: rtl/key_mode_ctrl_if.sv
// Key/mode signal bundle between the push-button front end and the clock core.
// master drives the raw keys and ALARM_ON; slave (key_mode_ctrl) returns mode flags and debounced keys.
interface key_mode_ctrl_if;
    logic KEY0;
    logic KEY1;
    logic ALARM_ON;
    logic SET_TIME;
    logic SET_ALARM;
    logic SET_PULSE;
    logic KEY0_DB;
    logic KEY1_DB;

    modport master (
        output KEY0, KEY1, ALARM_ON,
        input  SET_TIME, SET_ALARM, SET_PULSE, KEY0_DB, KEY1_DB
    );

    modport slave (
        input  KEY0, KEY1, ALARM_ON,
        output SET_TIME, SET_ALARM, SET_PULSE, KEY0_DB, KEY1_DB
    );
endinterface

// File: rtl/key_mode_ctrl.sv
// Two-key debounce plus RUN/TSET/ASET mode controller for the alarm clock.
// Optional macro MODE_TIMEOUT_EN adds an idle timeout that returns a set mode to RUN.
module key_mode_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned TIMEOUT_CYCLES  = 1500000000
) (
    input  logic            CLOCK_50,
    input  logic            RESET,
    key_mode_ctrl_if.slave  bus
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_TSET = 2'b01,
        ST_ASET = 2'b10
    } state_t;

    // Bit 0 is KEY0 (mode), bit 1 is KEY1 (set/load); all key levels are active-low.
    logic [1:0]      meta_r;
    logic [1:0]      sync_r;
    logic [1:0]      db_r;
    logic [1:0]      db_d_r;
    logic [DB_W-1:0] db_cnt_r [2];
    logic [1:0]      press_s;

    state_t          state_r;
    state_t          state_next_s;
    logic            set_time_r;
    logic            set_alarm_r;
    logic            set_pulse_r;
    logic            pulse_next_s;
    logic            timeout_s;

    // Synchronizers and per-key debounce counters.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            meta_r      <= 2'b11;
            sync_r      <= 2'b11;
            db_r        <= 2'b11;
            db_d_r      <= 2'b11;
            db_cnt_r[0] <= '0;
            db_cnt_r[1] <= '0;
        end else begin
            meta_r <= {bus.KEY1, bus.KEY0};
            sync_r <= meta_r;
            db_d_r <= db_r;
            for (int i = 0; i < 2; i++) begin
                if (sync_r[i] != db_r[i]) begin
                    if (db_cnt_r[i] == DB_LAST) begin
                        db_r[i]     <= sync_r[i];
                        db_cnt_r[i] <= '0;
                    end else begin
                        db_cnt_r[i] <= db_cnt_r[i] + DB_W'(1);
                    end
                end else begin
                    db_cnt_r[i] <= '0;
                end
            end
        end
    end

    // A press is the first cycle the debounced level reads low; releases are ignored.
    assign press_s = db_d_r & ~db_r;

`ifdef MODE_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt_r;

    // A press in the expiry cycle restarts the idle window instead of exiting.
    assign timeout_s = (state_r != ST_RUN) && (tmo_cnt_r == TMO_LAST) && (press_s == 2'b00);

    // Idle counter: runs only while a set mode persists with no key activity.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            tmo_cnt_r <= '0;
        end else if ((state_r == ST_RUN) || (state_next_s == ST_RUN) || (press_s != 2'b00)) begin
            tmo_cnt_r <= '0;
        end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
        end
    end
`else
    logic [31:0] timeout_cfg_unused_s;

    assign timeout_cfg_unused_s = 32'(TIMEOUT_CYCLES);
    assign timeout_s            = 1'b0;
`endif

    // Next-state and strobe decode; KEY0 takes priority over KEY1 in the same cycle.
    always_comb begin
        state_next_s = state_r;
        pulse_next_s = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (press_s[0]) begin
                    state_next_s = bus.ALARM_ON ? ST_ASET : ST_TSET;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_TSET: begin
                if (press_s[0] || timeout_s) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_TSET;
                end
                pulse_next_s = press_s[1] & ~press_s[0];
            end
            ST_ASET: begin
                if (press_s[0] || !bus.ALARM_ON || timeout_s) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_ASET;
                end
                pulse_next_s = press_s[1] & ~press_s[0];
            end
            default: begin
                state_next_s = ST_RUN;
                pulse_next_s = 1'b0;
            end
        endcase
    end

    // State register and registered mode outputs.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_r     <= ST_RUN;
            set_time_r  <= 1'b0;
            set_alarm_r <= 1'b0;
            set_pulse_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            set_time_r  <= (state_next_s == ST_TSET);
            set_alarm_r <= (state_next_s == ST_ASET);
            set_pulse_r <= pulse_next_s;
        end
    end

    assign bus.SET_TIME  = set_time_r;
    assign bus.SET_ALARM = set_alarm_r;
    assign bus.SET_PULSE = set_pulse_r;
    assign bus.KEY0_DB   = db_r[0];
    assign bus.KEY1_DB   = db_r[1];

endmodule

// File: tb/tb_key_mode_ctrl.sv
// Self-checking bench for key_mode_ctrl: directed scenarios plus random key activity
// compared every cycle against a behavioural model of the key/mode rules.
module tb_key_mode_ctrl;

    localparam int DEB = 4;
    localparam int TMO = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    key_mode_ctrl_if bus_if ();

    key_mode_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .TIMEOUT_CYCLES  (TMO)
    ) dut (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .bus      (bus_if)
    );

    always #5 clk = ~clk;

    // Model state: index 0 = KEY0, 1 = KEY1. Mode 0 = RUN, 1 = time set, 2 = alarm set.
    bit m_meta [2];
    bit m_sync [2];
    bit m_db   [2];
    bit m_fell [2];
    int m_run  [2];
    int m_mode;
    bit m_pulse;
    int m_idle;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit raw [2];
        bit p0, p1, old_db, tmo_hit;
        int nmode;
        raw[0] = bus_if.KEY0;
        raw[1] = bus_if.KEY1;
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_meta[i] = 1'b1; m_sync[i] = 1'b1; m_db[i] = 1'b1;
                m_fell[i] = 1'b0; m_run[i]  = 0;
            end
            m_mode = 0; m_pulse = 1'b0; m_idle = 0;
        end else begin
            p0 = m_fell[0];
            p1 = m_fell[1];
            for (int i = 0; i < 2; i++) begin
                old_db = m_db[i];
                // accept the synchronized level once it has disagreed for DEB edges in a row
                if (m_sync[i] != m_db[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEB) begin
                        m_db[i]  = m_sync[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
                m_fell[i] = old_db && !m_db[i];
                m_sync[i] = m_meta[i];
                m_meta[i] = raw[i];
            end
`ifdef MODE_TIMEOUT_EN
            tmo_hit = (m_mode != 0) && (m_idle == TMO - 1) && !p0 && !p1;
`else
            tmo_hit = 1'b0;
`endif
            if (p0)                               nmode = (m_mode == 0) ? (bus_if.ALARM_ON ? 2 : 1) : 0;
            else if (m_mode == 2 && !bus_if.ALARM_ON) nmode = 0;
            else if (tmo_hit)                     nmode = 0;
            else                                  nmode = m_mode;
            m_pulse = p1 && !p0 && (m_mode != 0);
            m_idle  = (m_mode == 0 || nmode == 0 || p0 || p1) ? 0 : m_idle + 1;
            m_mode  = nmode;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        chk("set_time",  bus_if.SET_TIME,  int'(m_mode == 1));
        chk("set_alarm", bus_if.SET_ALARM, int'(m_mode == 2));
        chk("set_pulse", bus_if.SET_PULSE, int'(m_pulse));
        chk("key0_db",   bus_if.KEY0_DB,   int'(m_db[0]));
        chk("key1_db",   bus_if.KEY1_DB,   int'(m_db[1]));
    endtask

    task automatic hold_keys(input bit k0, input bit k1, input int low_cyc, output int pulses);
        pulses = 0;
        if (k0) bus_if.KEY0 = 1'b0;
        if (k1) bus_if.KEY1 = 1'b0;
        repeat (low_cyc) begin
            step();
            pulses += int'(bus_if.SET_PULSE);
        end
        bus_if.KEY0 = 1'b1;
        bus_if.KEY1 = 1'b1;
        repeat (8) begin
            step();
            pulses += int'(bus_if.SET_PULSE);
        end
    endtask

    initial begin
        int pulses;
        int waited;
        bus_if.KEY0     = 1'b1;
        bus_if.KEY1     = 1'b1;
        bus_if.ALARM_ON = 1'b0;
        rst             = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        step();
        chk("rst_key0_db",   bus_if.KEY0_DB,   1);
        chk("rst_key1_db",   bus_if.KEY1_DB,   1);
        chk("rst_set_time",  bus_if.SET_TIME,  0);
        chk("rst_set_alarm", bus_if.SET_ALARM, 0);
        chk("rst_set_pulse", bus_if.SET_PULSE, 0);

        // three-cycle glitch must be rejected
        bus_if.KEY0 = 1'b0;
        repeat (3) step();
        bus_if.KEY0 = 1'b1;
        repeat (10) step();
        chk("glitch_key0_db",  bus_if.KEY0_DB,  1);
        chk("glitch_set_time", bus_if.SET_TIME, 0);

        // held press: KEY0_DB low after edge k+5, SET_TIME one cycle later
        bus_if.KEY0 = 1'b0;
        step();
        repeat (4) step();
        chk("db_k4_high", bus_if.KEY0_DB, 1);
        step();
        chk("db_k5_low",   bus_if.KEY0_DB,  0);
        chk("tset_k5_low", bus_if.SET_TIME, 0);
        step();
        chk("tset_k6_high",  bus_if.SET_TIME,  1);
        chk("aset_k6_low",   bus_if.SET_ALARM, 0);
        repeat (6) step();
        bus_if.KEY0 = 1'b1;
        repeat (10) step();
        chk("tset_after_release", bus_if.SET_TIME, 1);

        hold_keys(1'b0, 1'b1, 12, pulses);
        chk("pulse_in_tset", pulses, 1);
        hold_keys(1'b1, 1'b0, 12, pulses);
        chk("back_to_run", bus_if.SET_TIME, 0);
        hold_keys(1'b0, 1'b1, 12, pulses);
        chk("pulse_in_run", pulses, 0);

        bus_if.ALARM_ON = 1'b1;
        hold_keys(1'b1, 1'b0, 12, pulses);
        chk("aset_entry", bus_if.SET_ALARM, 1);
        chk("aset_tset",  bus_if.SET_TIME,  0);
        bus_if.ALARM_ON = 1'b0;
        step();
        chk("aset_drop", bus_if.SET_ALARM, 0);

        hold_keys(1'b1, 1'b0, 12, pulses);
        chk("tset_again", bus_if.SET_TIME, 1);
        hold_keys(1'b1, 1'b1, 12, pulses);
        chk("both_no_pulse", pulses, 0);
        chk("both_to_run",   bus_if.SET_TIME, 0);

        // enter TSET and observe idle behaviour from the entry cycle
        bus_if.KEY0 = 1'b0;
        waited = 0;
        while (bus_if.SET_TIME !== 1'b1 && waited < 20) begin
            step();
            waited++;
        end
        chk("tset_entry_seen", int'(bus_if.SET_TIME), 1);
        bus_if.KEY0 = 1'b1;
`ifdef MODE_TIMEOUT_EN
        repeat (19) step();
        chk("tmo_before", bus_if.SET_TIME, 1);
        step();
        chk("tmo_exit", bus_if.SET_TIME, 0);
`else
        repeat (100) step();
        chk("no_tmo_hold", bus_if.SET_TIME, 1);
        hold_keys(1'b1, 1'b0, 12, pulses);
        chk("no_tmo_exit", bus_if.SET_TIME, 0);
`endif

        // reset while in ASET with a debounce in progress
        bus_if.ALARM_ON = 1'b1;
        hold_keys(1'b1, 1'b0, 12, pulses);
        chk("aset_before_rst", bus_if.SET_ALARM, 1);
        bus_if.KEY1 = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        step();
        chk("mid_rst_set_alarm", bus_if.SET_ALARM, 0);
        chk("mid_rst_set_time",  bus_if.SET_TIME,  0);
        chk("mid_rst_set_pulse", bus_if.SET_PULSE, 0);
        chk("mid_rst_key0_db",   bus_if.KEY0_DB,   1);
        chk("mid_rst_key1_db",   bus_if.KEY1_DB,   1);
        rst = 1'b0;
        repeat (12) step();
        chk("held_through_rst", bus_if.KEY1_DB, 0);
        bus_if.KEY1 = 1'b1;
        repeat (10) step();
        bus_if.ALARM_ON = 1'b0;

        // random key activity with bounces, alarm switch changes and rare resets
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(5) == 0) bus_if.KEY0 = ~bus_if.KEY0;
            if ($urandom_range(5) == 0) bus_if.KEY1 = ~bus_if.KEY1;
            if ($urandom_range(39) == 0) bus_if.ALARM_ON = ~bus_if.ALARM_ON;
            rst = ($urandom_range(499) == 0);
            step();
        end
        rst = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/key_mode_ctrl.md
KEY_MODE_CTRL -- requirements
Module: key_mode_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning consecutive stable CLOCK_50 cycles needed to accept a key level change (10 ms at 50 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1500000000, meaning idle CLOCK_50 cycles before a set mode auto-exits (30 s); used only under MODE_TIMEOUT_EN.
REQ-003 SHALL have port CLOCK_50  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port RESET  input  1  synchronous active-high reset.
REQ-005 SHALL have port KEY0  input  1  raw asynchronous push-button, active-low; mode key.
REQ-006 SHALL have port KEY1  input  1  raw asynchronous push-button, active-low; set/load key.
REQ-007 SHALL have port ALARM_ON  input  1  level from SW[9]; selects alarm-set vs time-set entry.
REQ-008 SHALL have port SET_TIME  output  1  registered; high while in time-set mode.
REQ-009 SHALL have port SET_ALARM  output  1  registered; high while in alarm-set mode.
REQ-010 SHALL have port SET_PULSE  output  1  registered one-cycle strobe: accepted KEY1 press while in a set mode.
REQ-011 SHALL have port KEY0_DB  output  1  debounced KEY0 level (active-low).
REQ-012 SHALL have port KEY1_DB  output  1  debounced KEY1 level (active-low).

Function
REQ-013 Each key SHALL pass a 2-flop synchronizer before any other use.
REQ-014 Per key, a counter SHALL increment while synchronized level != debounced level and clear when equal; at count DEBOUNCE_CYCLES-1 the debounced level SHALL take the synchronized level and the counter SHALL clear.
REQ-015 Key held low from edge k with no bounce: KEY*_DB SHALL go low after edge k+1+DEBOUNCE_CYCLES; bounce shorter than DEBOUNCE_CYCLES SHALL produce no change.
REQ-016 A press event SHALL be a 1->0 transition of KEY*_DB, flagged internally in the same cycle KEY*_DB first reads 0; release (0->1) SHALL generate no event.
REQ-017 FSM states SHALL be RUN, TSET, ASET, one-hot visible as SET_TIME=(TSET), SET_ALARM=(ASET); both never high together.
REQ-018 RUN + KEY0 press: ALARM_ON=1 -> ASET, else -> TSET; outputs update one cycle after the press event.
REQ-019 TSET or ASET + KEY0 press -> RUN.
REQ-020 ASET with ALARM_ON=0 SHALL -> RUN next cycle; ALARM_ON change in TSET or RUN SHALL have no effect.
REQ-021 SET_PULSE SHALL be high exactly one cycle, one cycle after a KEY1 press event, only if state is TSET or ASET at the event; KEY1 in RUN SHALL be ignored.
REQ-022 KEY0 and KEY1 press events in the same cycle: KEY0 transition SHALL apply, SET_PULSE SHALL be suppressed.
REQ-023 Holding a key SHALL produce exactly one event per press; no auto-repeat.

Reset
REQ-024 On RESET=1 at a clock edge: state=RUN, SET_TIME=0, SET_ALARM=0, SET_PULSE=0, sync flops=1, KEY0_DB=KEY1_DB=1, all counters=0.
REQ-025 RESET mid-debounce or mid-mode SHALL abandon it; a key held low through reset release SHALL yield one press event after full debounce.

Configuration
REQ-026 Macro MODE_TIMEOUT_EN defined: a counter SHALL clear on entry to TSET/ASET and on any KEY0/KEY1 press event, increment each cycle in TSET/ASET, and at TIMEOUT_CYCLES-1 force RUN next cycle; counter held at 0 in RUN.
REQ-027 MODE_TIMEOUT_EN undefined: no timeout counter SHALL exist; TSET/ASET persist until KEY0 or REQ-020.

Verification (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=20)
REQ-028 KEY0 low held, ALARM_ON=0 -> KEY0_DB low after edge k+5, SET_TIME=1 one cycle later, SET_ALARM=0.
REQ-029 KEY0 glitch low 3 cycles then high -> KEY0_DB stays 1, state stays RUN.
REQ-030 In TSET, KEY1 press -> SET_PULSE high exactly 1 cycle; same KEY1 press in RUN -> SET_PULSE stays 0.
REQ-031 In ASET, drop ALARM_ON -> SET_ALARM=0 next cycle; KEY0 and KEY1 events same cycle in TSET -> RUN, no SET_PULSE.
REQ-032 MODE_TIMEOUT_EN defined: enter TSET, no keys -> RUN after 20 cycles; KEY1 press at cycle 15 restarts count. Undefined: TSET held 100 cycles.
REQ-033 RESET asserted in ASET with counters mid-count -> all outputs per REQ-024 after that edge.
